// File: rtl/telem_pkg.sv
// ----------------------------------------------------------------------------
// telem_pkg : shared constants and types for the telemetry frame scheduler
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package telem_pkg;

  localparam logic [7:0] c_HDR0      = 8'hA5;
  localparam logic [7:0] c_HDR1      = 8'h5A;
  localparam int         c_IDX_W     = 4;
  localparam int         c_FRAME_LEN = 11;
  localparam int         c_NUM_CH    = 4;

  typedef logic [c_IDX_W-1:0] idx_t;

  localparam idx_t c_CHK_IDX = idx_t'(c_FRAME_LEN - 1);

  localparam logic [1:0] c_ST_IDLE      = 2'd0;
  localparam logic [1:0] c_ST_ISSUE     = 2'd1;
  localparam logic [1:0] c_ST_WAIT_ACK  = 2'd2;
  localparam logic [1:0] c_ST_WAIT_DONE = 2'd3;

  typedef struct packed {
    logic        dir;
    logic [14:0] speed;
  } chan_t;

endpackage

`default_nettype wire

// File: rtl/telem_frame_sched_if.sv
// ----------------------------------------------------------------------------
// telem_frame_sched_if : measurement inputs and UART byte handshake bundle
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface telem_frame_sched_if;

  logic        send_tick;
  logic [3:0]  ch_en;
  logic [14:0] speed0;
  logic [14:0] speed1;
  logic [14:0] speed2;
  logic [14:0] speed3;
  logic [3:0]  dir;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        frame_busy;
  logic        frame_done;
  logic [7:0]  overrun_cnt;
  logic        ack_err;

  modport master (
    output send_tick, ch_en, speed0, speed1, speed2, speed3, dir, tx_busy,
    input  tx_start, tx_data, frame_busy, frame_done, overrun_cnt, ack_err
  );

  modport slave (
    input  send_tick, ch_en, speed0, speed1, speed2, speed3, dir, tx_busy,
    output tx_start, tx_data, frame_busy, frame_done, overrun_cnt, ack_err
  );

endinterface

`default_nettype wire

// File: rtl/telem_frame_pack.sv
// ----------------------------------------------------------------------------
// telem_frame_pack : combinational frame byte select with checksum adder tree
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module telem_frame_pack
  import telem_pkg::*;
#(
  parameter logic [7:0] HDR0 = c_HDR0,
  parameter logic [7:0] HDR1 = c_HDR1
) (
  input  chan_t [c_NUM_CH-1:0] snap,
  input  logic  [c_NUM_CH-1:0] en,
  input  idx_t                 byte_idx,
  output logic  [7:0]          frame_byte
);

  logic [7:0] w_body [0:2*c_NUM_CH-1];
  logic [7:0] w_pair [0:c_NUM_CH-1];
  logic [7:0] w_chk;

  // Disabled channels read as zero so they also drop out of the checksum.
  for (genvar gi = 0; gi < c_NUM_CH; gi++) begin : g_chan
    assign w_body[2*gi]   = en[gi] ? {snap[gi].dir, snap[gi].speed[14:8]} : 8'h00;
    assign w_body[2*gi+1] = en[gi] ? snap[gi].speed[7:0] : 8'h00;
    assign w_pair[gi]     = w_body[2*gi] + w_body[2*gi+1];
  end

  assign w_chk = (w_pair[0] + w_pair[1]) + (w_pair[2] + w_pair[3]);

  always_comb begin
    frame_byte = 8'h00;
    case (byte_idx)
      idx_t'(0):  frame_byte = HDR0;
      idx_t'(1):  frame_byte = HDR1;
      idx_t'(2):  frame_byte = w_body[0];
      idx_t'(3):  frame_byte = w_body[1];
      idx_t'(4):  frame_byte = w_body[2];
      idx_t'(5):  frame_byte = w_body[3];
      idx_t'(6):  frame_byte = w_body[4];
      idx_t'(7):  frame_byte = w_body[5];
      idx_t'(8):  frame_byte = w_body[6];
      idx_t'(9):  frame_byte = w_body[7];
      c_CHK_IDX:  frame_byte = w_chk;
      default:    frame_byte = 8'h00;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/telem_frame_sched.sv
// ----------------------------------------------------------------------------
// telem_frame_sched : snapshots encoder data, streams an 11-byte frame to UART
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module telem_frame_sched
  import telem_pkg::*;
#(
  parameter logic [7:0] HDR0        = c_HDR0,
  parameter logic [7:0] HDR1        = c_HDR1,
  parameter int         ACK_TIMEOUT = 16
) (
  input wire logic           sys_clk,
  input wire logic           sys_rst,
  telem_frame_sched_if.slave bus
);

  localparam int c_TO_W = $clog2(ACK_TIMEOUT + 1);

  logic [1:0]              r_state;
  idx_t                    r_byte_idx;
  chan_t [c_NUM_CH-1:0]    r_snap;
  logic  [c_NUM_CH-1:0]    r_en;
  logic  [c_TO_W-1:0]      r_to_cnt;
  logic                    r_tx_start;
  logic  [7:0]             r_tx_data;
  logic  [7:0]             r_ovr;
  logic                    r_ack_err;
  logic  [7:0]             w_frame_byte;
  logic                    w_last_done;

  telem_frame_pack #(
    .HDR0 (HDR0),
    .HDR1 (HDR1)
  ) u_pack (
    .snap       (r_snap),
    .en         (r_en),
    .byte_idx   (r_byte_idx),
    .frame_byte (w_frame_byte)
  );

  // Completion is flagged while still in WAIT_DONE, so a coincident tick is an overrun.
  assign w_last_done = (r_state == c_ST_WAIT_DONE) && !bus.tx_busy
                       && (r_byte_idx == c_CHK_IDX);

  assign bus.tx_start    = r_tx_start;
  assign bus.tx_data     = r_tx_data;
  assign bus.frame_busy  = (r_state != c_ST_IDLE);
  assign bus.frame_done  = w_last_done && !sys_rst;
  assign bus.overrun_cnt = r_ovr;
  assign bus.ack_err     = r_ack_err;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state    <= c_ST_IDLE;
      r_byte_idx <= '0;
      r_snap     <= '0;
      r_en       <= '0;
      r_to_cnt   <= '0;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
      r_ovr      <= 8'h00;
      r_ack_err  <= 1'b0;
    end else begin
      r_tx_start <= 1'b0;

      if (bus.send_tick && (r_state != c_ST_IDLE) && (r_ovr != 8'hFF)) begin
        r_ovr <= r_ovr + 8'd1;
      end

      case (r_state)
        c_ST_IDLE: begin
          if (bus.send_tick) begin
            r_snap[0]  <= {bus.dir[0], bus.speed0};
            r_snap[1]  <= {bus.dir[1], bus.speed1};
            r_snap[2]  <= {bus.dir[2], bus.speed2};
            r_snap[3]  <= {bus.dir[3], bus.speed3};
            r_en       <= bus.ch_en;
            r_ack_err  <= 1'b0;
            r_byte_idx <= '0;
            r_state    <= c_ST_ISSUE;
          end
        end

        c_ST_ISSUE: begin
          if (!bus.tx_busy) begin
            r_tx_start <= 1'b1;
            r_tx_data  <= w_frame_byte;
            r_to_cnt   <= '0;
            r_state    <= c_ST_WAIT_ACK;
          end
        end

        c_ST_WAIT_ACK: begin
          if (bus.tx_busy) begin
            r_state <= c_ST_WAIT_DONE;
          end else if (r_to_cnt == c_TO_W'(ACK_TIMEOUT - 1)) begin
            r_ack_err <= 1'b1;
            r_state   <= c_ST_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + c_TO_W'(1);
          end
        end

        c_ST_WAIT_DONE: begin
          if (!bus.tx_busy) begin
            if (r_byte_idx == c_CHK_IDX) begin
              r_state <= c_ST_IDLE;
            end else begin
              r_byte_idx <= r_byte_idx + idx_t'(1);
              r_state    <= c_ST_ISSUE;
            end
          end
        end

        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_telem_frame_sched.sv
// ----------------------------------------------------------------------------
// tb_telem_frame_sched : directed vector bench with a 10-cycle UART model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_telem_frame_sched;
  import telem_pkg::*;

  typedef struct {
    logic [3:0]       en;
    logic [3:0]       dir;
    logic [14:0]      sp0;
    logic [14:0]      sp1;
    logic [14:0]      sp2;
    logic [14:0]      sp3;
    logic [10:0][7:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  telem_frame_sched_if bus ();

  telem_frame_sched #(
    .HDR0        (8'hA5),
    .HDR1        (8'h5A),
    .ACK_TIMEOUT (16)
  ) dut (
    .sys_clk (clk),
    .sys_rst (rst),
    .bus     (bus)
  );

  // UART model: busy for 10 cycles after each accepted start strobe, or mute.
  int   uart_mute  = 0;
  logic force_busy = 1'b0;
  logic model_busy = 1'b0;
  int   model_cnt  = 0;
  assign bus.tx_busy = model_busy | force_busy;

  always @(posedge clk) begin
    if (model_busy) begin
      if (model_cnt <= 1) model_busy <= 1'b0;
      else                model_cnt  <= model_cnt - 1;
    end else if (bus.tx_start && (uart_mute == 0)) begin
      model_busy <= 1'b1;
      model_cnt  <= 10;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] cap [$];
  int   start_cnt  = 0;
  int   done_cnt   = 0;
  int   proto_err  = 0;
  int   start_cyc  = 0;
  logic prev_start = 1'b0;

  always @(negedge clk) begin
    if (bus.tx_start) begin
      cap.push_back(bus.tx_data);
      start_cnt = start_cnt + 1;
      start_cyc = cyc;
      if (bus.tx_busy || prev_start) proto_err = proto_err + 1;
    end
    prev_start = bus.tx_start;
    if (bus.frame_done) done_cnt = done_cnt + 1;
  end

  int n_tests = 0;
  int n_fail  = 0;
  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0][7:0] fb(
    input logic [7:0] b0, b1, b2, b3, b4, b5, b6, b7, b8, b9, b10);
    fb = {b10, b9, b8, b7, b6, b5, b4, b3, b2, b1, b0};
  endfunction

  task automatic drive(input int vi);
    bus.ch_en  = vecs[vi].en;
    bus.dir    = vecs[vi].dir;
    bus.speed0 = vecs[vi].sp0;
    bus.speed1 = vecs[vi].sp1;
    bus.speed2 = vecs[vi].sp2;
    bus.speed3 = vecs[vi].sp3;
  endtask

  task automatic scramble();
    bus.ch_en  = ~bus.ch_en;
    bus.dir    = ~bus.dir;
    bus.speed0 = ~bus.speed0;
    bus.speed1 = ~bus.speed1;
    bus.speed2 = 15'h2AAA;
    bus.speed3 = 15'h5555;
  endtask

  task automatic tick();
    @(negedge clk);
    bus.send_tick = 1'b1;
    @(negedge clk);
    bus.send_tick = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while (bus.frame_busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, bus.frame_busy}, 32'd0);
  endtask

  task automatic compare_frame(input int vi, input int d0, input string tag);
    logic [7:0] got;
    check($sformatf("%s_len", tag), cap.size(), 11);
    for (int b = 0; b < 11; b++) begin
      got = (b < cap.size()) ? cap[b] : 8'hxx;
      check($sformatf("%s_byte%0d", tag, b), {24'd0, got}, {24'd0, vecs[vi].exp[b]});
    end
    check($sformatf("%s_done", tag), done_cnt - d0, 1);
    check($sformatf("%s_ackerr", tag), {31'd0, bus.ack_err}, 32'd0);
  endtask

  task automatic run_vec(input int vi);
    int d0;
    drive(vi);
    cap.delete();
    d0 = done_cnt;
    tick();
    scramble();
    wait_idle(400, $sformatf("v%0d_idle", vi));
    @(negedge clk);
    compare_frame(vi, d0, $sformatf("v%0d", vi));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, s0, t0, n, extra;

    vecs[0] = '{4'hF, 4'b0001, 15'h1234, 15'h0000, 15'h0000, 15'h0000,
                fb(8'hA5, 8'h5A, 8'h92, 8'h34, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hC6)};
    vecs[1] = '{4'b1010, 4'hF, 15'h7FFF, 15'h7FFF, 15'h7FFF, 15'h7FFF,
                fb(8'hA5, 8'h5A, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFC)};
    vecs[2] = '{4'b0100, 4'b0100, 15'h7FFF, 15'h7FFF, 15'h0101, 15'h7FFF,
                fb(8'hA5, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h81, 8'h01, 8'h00, 8'h00, 8'h82)};
    vecs[3] = '{4'hF, 4'b0000, 15'h0001, 15'h0100, 15'h4000, 15'h00FF,
                fb(8'hA5, 8'h5A, 8'h00, 8'h01, 8'h01, 8'h00, 8'h40, 8'h00, 8'h00, 8'hFF, 8'h41)};

    rst = 1'b1;
    bus.send_tick = 1'b0;
    drive(0);
    repeat (3) @(negedge clk);
    check("rst_tx_start",   {31'd0, bus.tx_start},   0);
    check("rst_tx_data",    {24'd0, bus.tx_data},    0);
    check("rst_frame_busy", {31'd0, bus.frame_busy}, 0);
    check("rst_frame_done", {31'd0, bus.frame_done}, 0);
    check("rst_overrun",    {24'd0, bus.overrun_cnt}, 0);
    check("rst_ack_err",    {31'd0, bus.ack_err},    0);
    rst = 1'b0;
    @(negedge clk);

    for (int vi = 0; vi < 4; vi++) run_vec(vi);

    // Overrun: extra ticks every 5 cycles while the frame is in flight.
    drive(0);
    cap.delete();
    d0 = done_cnt;
    tick();
    extra = 0;
    for (int k = 0; k < 200; k++) begin
      repeat (4) @(negedge clk);
      if (bus.frame_done || !bus.frame_busy) break;
      bus.send_tick = 1'b1;
      @(negedge clk);
      bus.send_tick = 1'b0;
      extra++;
    end
    wait_idle(400, "ovr_idle");
    @(negedge clk);
    compare_frame(0, d0, "ovr");
    check("ovr_count", {24'd0, bus.overrun_cnt}, extra);
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      bus.send_tick = 1'b1;
      @(negedge clk);
      bus.send_tick = 1'b0;
    end
    check("ovr_saturate", {24'd0, bus.overrun_cnt}, 255);
    wait_idle(400, "ovr_sat_idle");
    repeat (15) @(negedge clk);

    // Timeout: the UART never acknowledges.
    uart_mute = 1;
    drive(0);
    cap.delete();
    d0 = done_cnt;
    s0 = start_cnt;
    tick();
    n = 0;
    while (start_cnt == s0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("to_start_seen", start_cnt - s0, 1);
    t0 = start_cyc;
    n = 0;
    while (!bus.ack_err && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("to_ack_err", {31'd0, bus.ack_err}, 1);
    check("to_latency", cyc - t0, 16);
    check("to_idle", {31'd0, bus.frame_busy}, 0);
    repeat (5) @(negedge clk);
    check("to_sticky", {31'd0, bus.ack_err}, 1);
    check("to_no_done", done_cnt - d0, 0);
    check("to_one_start", start_cnt - s0, 1);
    uart_mute = 0;
    cap.delete();
    d0 = done_cnt;
    tick();
    check("to_clear", {31'd0, bus.ack_err}, 0);
    wait_idle(400, "to_next_idle");
    @(negedge clk);
    compare_frame(0, d0, "to_next");

    // Reset while byte 5 is on the wire.
    drive(1);
    cap.delete();
    tick();
    n = 0;
    while (cap.size() < 6 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("mr_reached_b5", cap.size(), 6);
    rst = 1'b1;
    @(negedge clk);
    check("mr_tx_start",   {31'd0, bus.tx_start},    0);
    check("mr_tx_data",    {24'd0, bus.tx_data},     0);
    check("mr_frame_busy", {31'd0, bus.frame_busy},  0);
    check("mr_frame_done", {31'd0, bus.frame_done},  0);
    check("mr_overrun",    {24'd0, bus.overrun_cnt}, 0);
    check("mr_ack_err",    {31'd0, bus.ack_err},     0);
    rst = 1'b0;
    s0 = start_cnt;
    repeat (30) @(negedge clk);
    check("mr_no_start", start_cnt - s0, 0);
    run_vec(1);

    // Transmitter already busy when the tick arrives.
    force_busy = 1'b1;
    drive(2);
    cap.delete();
    d0 = done_cnt;
    s0 = start_cnt;
    tick();
    repeat (50) @(negedge clk);
    check("bh_no_start",   start_cnt - s0, 0);
    check("bh_frame_busy", {31'd0, bus.frame_busy}, 1);
    force_busy = 1'b0;
    wait_idle(400, "bh_idle");
    @(negedge clk);
    compare_frame(2, d0, "bh");

    check("proto_start_rules", proto_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/telem_frame_sched.md
Name: telem_frame_sched

Overview:
Scheduler that turns the four wheel-encoder measurements (15-bit speed plus direction per channel) into a fixed 11-byte telemetry frame. It sequences the frame one byte at a time into the byte-wide UART transmitter using a start/busy handshake.
It sits between the per-channel meter/dir outputs and the UART transmit block, and is triggered by the periodic send tick.
It also supervises the transmitter: overlapping send requests are counted as overruns, and a transmitter that never acknowledges a byte causes the frame to be aborted.

Parameters:
HDR0, 8'hA5, first header byte
HDR1, 8'h5A, second header byte
ACK_TIMEOUT, 16, cycles to wait in WAIT_ACK for tx_busy to rise before aborting

Ports:
sys_clk  in  1  system clock; all logic on rising edge
sys_rst  in  1  synchronous, active-high reset
send_tick  in  1  one-cycle request to send a frame
ch_en  in  4  per-channel enable, sampled with the snapshot
speed0..speed3  in  15 each  channel speed measurements
dir  in  4  channel direction bits, bit i belongs to channel i
tx_busy  in  1  transmitter busy; high while a byte is being shifted out
tx_start  out  1  registered one-cycle byte-start strobe
tx_data  out  8  registered byte, valid in the cycle tx_start is high
frame_busy  out  1  high whenever state != IDLE
frame_done  out  1  one-cycle pulse after the last byte completes
overrun_cnt  out  8  saturating count of rejected send_tick requests
ack_err  out  1  sticky flag: a frame was aborted on ACK_TIMEOUT

Behaviour:
- Reset values: state IDLE, tx_start=0, tx_data=0, frame_done=0, overrun_cnt=0, ack_err=0, byte_idx=0, snapshot=0. Reset mid-frame discards the frame immediately; no further tx_start is issued.
- Frame layout, byte index 0..10:
  - 0: HDR0. 1: HDR1.
  - 2+2i: {dir[i], speedi[14:8]}. 3+2i: speedi[7:0], for i = 0..3.
  - 10: checksum = sum mod 256 of bytes 2..9.
  - A channel with ch_en[i]=0 at snapshot time contributes 0x00, 0x00.
- Snapshot: in IDLE, send_tick=1 latches speeds, dir and ch_en. It also clears ack_err and byte_idx, and moves to ISSUE. Later input changes do not affect the frame in progress.
- States:
  - IDLE: waits for send_tick.
  - ISSUE: if tx_busy=0, register tx_start=1 and tx_data=byte[byte_idx], then go to WAIT_ACK. If tx_busy=1, stay in ISSUE.
  - WAIT_ACK:
    - tx_start returns to 0 and a timeout counter starts.
    - tx_busy=1 moves to WAIT_DONE.
    - ACK_TIMEOUT cycles with tx_busy=0 set ack_err=1 and return to IDLE, with no frame_done.
  - WAIT_DONE:
    - Waits for tx_busy=0.
    - If byte_idx=10: pulse frame_done and go to IDLE.
    - Otherwise: increment byte_idx and go to ISSUE.
- Latency: for a send_tick at edge k with tx_busy low, tx_start is high during the cycle after edge k+1.
- tx_start is never high for more than one cycle and is never asserted while tx_busy=1.
- Overrun: send_tick while state != IDLE is dropped and overrun_cnt increments, saturating at 255. This includes a send_tick in the same cycle as frame_done, because the state is still WAIT_DONE in that cycle. A send_tick arriving with sys_rst is ignored.
- Checksum is an 8-bit running sum, wrapping with the carry discarded. It is computed from the snapshot, not from the live inputs.

Decomposition:
- Shared package telem_pkg: HDR0/HDR1 defaults, FRAME_LEN=11, CHK_IDX=10, state enum (IDLE, ISSUE, WAIT_ACK, WAIT_DONE), byte_idx width (4).
- One sub-module, telem_frame_pack: combinational byte select. Inputs are the snapshot, the ch_en snapshot and byte_idx. Output is the frame byte, including the checksum adder tree.
- The FSM, timeout counter and overrun counter stay in telem_frame_sched.

Test Plan:
- Basic frame: ch_en=4'hF, speed0=15'h1234, dir=4'b0001, other speeds 0, one send_tick, bench UART model busy 10 cycles per byte. Required tx_data sequence: A5 5A 92 34 00 00 00 00 00 00 C6, then one frame_done pulse.
- Disable and wrap: speeds all 15'h7FFF, dir=4'hF, ch_en=4'b1010. Required: A5 5A 00 00 FF FF 00 00 FF FF FC, with the checksum wrapping mod 256.
- Overrun: send_tick every 5 cycles during a frame. Required: exactly one frame sent, overrun_cnt equal to the number of extra ticks. Continue for 300 extra ticks; overrun_cnt must hold at 255.
- Timeout: UART model never raises tx_busy. Required: ack_err=1 exactly ACK_TIMEOUT=16 cycles after tx_start, return to IDLE, no frame_done. The next send_tick clears ack_err.
- Reset mid-frame: assert sys_rst during byte 5. Required: all outputs at reset values the next cycle and no tx_start afterwards. A new tick then sends a complete, correct frame.
- Busy held: tx_busy held high at tick time for 50 cycles. Required: tx_start stays low until tx_busy falls, and the first byte is then A5.
